// File: rtl/pong_pkg.sv
// Shared definitions for the Pong set-score front end: state encoding,
// score width and the default timing constants for a 100 MHz clock.
package pong_pkg;

    typedef enum logic {
        SETUP = 1'b0,
        PLAY  = 1'b1
    } state_e;

    localparam int SCORE_W = 5;

    localparam int DEF_MIN_SCORE     = 1;
    localparam int DEF_MAX_SCORE     = 21;
    localparam int DEF_DEFAULT_SCORE = 5;

    localparam int DEF_DEBOUNCE      = 1_000_000;
    localparam int DEF_REPEAT_DELAY  = 50_000_000;
    localparam int DEF_REPEAT_PERIOD = 15_000_000;

endpackage

// File: rtl/btn_conditioner.sv
// One push-button front end: 2-flop synchroniser, debounce counter, rising-edge
// step pulse and optional hold-to-repeat. step_o is a registered one-cycle pulse.
module btn_conditioner
    import pong_pkg::*;
#(
    parameter int DEBOUNCE      = DEF_DEBOUNCE,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    input  logic rearm_i,
    output logic step_o
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DB_W    = $clog2(DEBOUNCE) + 1;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_phase_q, rpt_phase_d;
    logic             muted_q, muted_d;
    logic             step_q, step_d;

    always_comb begin
        sync1_d     = btn_i;
        sync2_d     = sync1_q;
        db_d        = db_q;
        db_cnt_d    = '0;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_phase_d = rpt_phase_q;
        step_d      = 1'b0;

        if (sync2_q != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d   = sync2_q;
                step_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // Repeat timing restarts from zero on the cycle the level first goes high.
        if (!db_q) begin
            rpt_cnt_d   = '0;
            rpt_phase_d = 1'b0;
        end else if (REPEAT_EN) begin
            if (rpt_cnt_q == (rpt_phase_q ? PERIOD_LAST : DELAY_LAST)) begin
                rpt_cnt_d   = '0;
                rpt_phase_d = 1'b1;
                step_d      = !(muted_q || rearm_i);
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end

        // A button held through a state change stays silent until released.
        muted_d = db_q && (muted_q || rearm_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            db_q        <= 1'b0;
            db_cnt_q    <= '0;
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
            muted_q     <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            db_cnt_q    <= db_cnt_d;
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
            muted_q     <= muted_d;
            step_q      <= step_d;
        end
    end

    assign step_o = step_q;

endmodule

// File: rtl/setscore_ctrl.sv
// SET SCORE screen sequencer: conditions up/down/ok, keeps the target score in
// [MIN_SCORE, MAX_SCORE] with wrap-around, and steps SETUP <-> PLAY.
module setscore_ctrl
    import pong_pkg::*;
#(
    parameter int MIN_SCORE     = DEF_MIN_SCORE,
    parameter int MAX_SCORE     = DEF_MAX_SCORE,
    parameter int DEFAULT_SCORE = DEF_DEFAULT_SCORE,
    parameter int DEBOUNCE      = DEF_DEBOUNCE,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_ok,
    input  logic               game_over,
    output logic [SCORE_W-1:0] target_score,
    output logic               show_setscore,
    output logic               in_play,
    output logic               game_start
);

    localparam logic [SCORE_W-1:0] MIN_S = SCORE_W'(MIN_SCORE);
    localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] DEF_S = SCORE_W'(DEFAULT_SCORE);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               show_q, show_d;
    logic               play_q, play_d;
    logic               start_q, start_d;
    logic               up_step, down_step, ok_step;
    logic               rearm;

    btn_conditioner #(
        .DEBOUNCE     (DEBOUNCE),
        .REPEAT_EN    (1'b1),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_up (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_up),
        .rearm_i(rearm),
        .step_o (up_step)
    );

    btn_conditioner #(
        .DEBOUNCE     (DEBOUNCE),
        .REPEAT_EN    (1'b1),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_down (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_down),
        .rearm_i(rearm),
        .step_o (down_step)
    );

    btn_conditioner #(
        .DEBOUNCE     (DEBOUNCE),
        .REPEAT_EN    (1'b0),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ok (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_ok),
        .rearm_i(rearm),
        .step_o (ok_step)
    );

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        start_d = 1'b0;

        case (state_q)
            SETUP: begin
                if (ok_step) begin
                    state_d = PLAY;
                    start_d = 1'b1;
                end else if (up_step && !down_step) begin
                    score_d = (score_q >= MAX_S) ? MIN_S : score_q + 1'b1;
                end else if (down_step && !up_step) begin
                    score_d = (score_q <= MIN_S) ? MAX_S : score_q - 1'b1;
                end
            end
            PLAY: begin
                if (game_over) begin
                    state_d = SETUP;
                end
            end
            default: state_d = SETUP;
        endcase

        show_d = (state_d == SETUP);
        play_d = (state_d == PLAY);
        rearm  = (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SETUP;
            score_q <= DEF_S;
            show_q  <= 1'b1;
            play_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            show_q  <= show_d;
            play_q  <= play_d;
            start_q <= start_d;
        end
    end

    assign target_score  = score_q;
    assign show_setscore = show_q;
    assign in_play       = play_q;
    assign game_start    = start_q;

endmodule

// File: tb/tb_setscore_ctrl.sv
// Directed bench for setscore_ctrl with short debounce/repeat timing; all
// expected values are hand-derived cycle counts from the raw button edge.
module tb_setscore_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic       btn_ok;
    logic       game_over;
    logic [4:0] target_score;
    logic       show_setscore;
    logic       in_play;
    logic       game_start;

    int n_cmp = 0;
    int n_err = 0;

    setscore_ctrl #(
        .MIN_SCORE    (1),
        .MAX_SCORE    (21),
        .DEFAULT_SCORE(5),
        .DEBOUNCE     (4),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_ok       (btn_ok),
        .game_over    (game_over),
        .target_score (target_score),
        .show_setscore(show_setscore),
        .in_play      (in_play),
        .game_start   (game_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int score, input bit show,
                              input bit play, input bit start);
        check_eq({tag, ".target"}, 32'(target_score), 32'(score));
        check_eq({tag, ".show"},   32'(show_setscore), 32'(show));
        check_eq({tag, ".play"},   32'(in_play), 32'(play));
        check_eq({tag, ".start"},  32'(game_start), 32'(start));
    endtask

    initial begin
        reset     = 1'b1;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_ok    = 1'b0;
        game_over = 1'b0;
        tick(2);
        check_outs("reset", 5, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        tick(1);

        // 1: clean press, new value lands 7 cycles after the raw edge
        btn_up = 1'b1;
        tick(6);
        check_eq("up_t6", 32'(target_score), 32'd5);
        tick(1);
        check_eq("up_t7", 32'(target_score), 32'd6);
        tick(3);
        btn_up = 1'b0;
        tick(12);
        check_eq("up_after", 32'(target_score), 32'd6);

        // 2: bouncing input never stays stable for 4 cycles
        for (int i = 0; i < 5; i++) begin
            btn_up = 1'b1;
            tick(2);
            btn_up = 1'b0;
            tick(2);
        end
        tick(10);
        check_eq("bounce", 32'(target_score), 32'd6);

        // 3: hold down from 5; steps at +7, +27, +35, +43, +51
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_eq("rst_mid", 32'(target_score), 32'd5);
        btn_down = 1'b1;
        tick(6);
        check_eq("dn_t6", 32'(target_score), 32'd5);
        tick(1);
        check_eq("dn_t7", 32'(target_score), 32'd4);
        tick(19);
        check_eq("dn_t26", 32'(target_score), 32'd4);
        tick(1);
        check_eq("dn_t27", 32'(target_score), 32'd3);
        tick(7);
        check_eq("dn_t34", 32'(target_score), 32'd3);
        tick(1);
        check_eq("dn_t35", 32'(target_score), 32'd2);
        tick(8);
        check_eq("dn_t43", 32'(target_score), 32'd1);
        tick(7);
        check_eq("dn_t50", 32'(target_score), 32'd1);
        tick(1);
        check_eq("dn_wrap", 32'(target_score), 32'd21);
        btn_down = 1'b0;
        tick(20);
        check_eq("dn_released", 32'(target_score), 32'd21);

        // 4: wrap above MAX, then simultaneous up+down held through repeats
        btn_up = 1'b1;
        tick(7);
        check_eq("up_wrap", 32'(target_score), 32'd1);
        btn_up = 1'b0;
        tick(12);
        btn_up   = 1'b1;
        btn_down = 1'b1;
        tick(30);
        check_eq("up_and_dn", 32'(target_score), 32'd1);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(12);

        // 5: ok starts play; up ignored; game_over returns with target kept
        btn_ok = 1'b1;
        tick(6);
        check_outs("ok_t6", 1, 1'b1, 1'b0, 1'b0);
        tick(1);
        check_outs("ok_t7", 1, 1'b0, 1'b1, 1'b1);
        tick(1);
        check_outs("ok_t8", 1, 1'b0, 1'b1, 1'b0);
        btn_ok = 1'b0;
        tick(10);
        btn_up = 1'b1;
        tick(30);
        check_eq("play_up", 32'(target_score), 32'd1);
        game_over = 1'b1;
        tick(1);
        game_over = 1'b0;
        check_outs("gover", 1, 1'b1, 1'b0, 1'b0);
        tick(40);
        check_eq("held_across", 32'(target_score), 32'd1);
        btn_up = 1'b0;
        tick(12);
        game_over = 1'b1;
        tick(1);
        game_over = 1'b0;
        check_outs("gover_setup", 1, 1'b1, 1'b0, 1'b0);
        tick(2);

        // 6: reset in PLAY while down is mid-repeat
        btn_ok = 1'b1;
        tick(7);
        check_eq("play2", 32'(in_play), 32'd1);
        btn_ok = 1'b0;
        tick(10);
        btn_down = 1'b1;
        tick(30);
        reset = 1'b1;
        tick(1);
        check_outs("rst_play", 5, 1'b1, 1'b0, 1'b0);
        reset    = 1'b0;
        btn_down = 1'b0;
        tick(15);
        check_outs("post_rst", 5, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
